clock_generator: RTL and testbench

CLOCK_GENERATOR -- requirements
Module: clock_generator

---
 rtl/clock_generator.sv | 58 +++++
 tb/tb_clock_generator.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/clock_generator.sv
// Programmable 50%-duty clock divider: clk_out half-period is 2^sel clk cycles.
// Optional macro CLKGEN_SEL_SYNC_EN puts sel through a 2-flop synchroniser first.
module clock_generator #(
  parameter logic [2:0] RESET_SEL = 3'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sel,
  output logic       clk_out
);

  logic [7:0] cnt;
  logic [2:0] asel;
  logic [2:0] sel_use;
  logic [7:0] term;
  logic       at_term;

`ifdef CLKGEN_SEL_SYNC_EN
  logic [2:0] sel_s1;
  logic [2:0] sel_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_s1 <= 3'd0;
      sel_s2 <= 3'd0;
    end else begin
      sel_s1 <= sel;
      sel_s2 <= sel_s1;
    end
  end

  assign sel_use = sel_s2;
`else
  assign sel_use = sel;
`endif

  // Terminal count of the active half-period; at most 127 for asel = 7.
  assign term    = (8'd1 << asel) - 8'd1;
  assign at_term = (cnt == term);

  // asel only reloads on the falling toggle, so a period in flight is never altered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 8'd0;
      clk_out <= 1'b0;
      asel    <= RESET_SEL;
    end else if (at_term) begin
      cnt     <= 8'd0;
      clk_out <= ~clk_out;
      if (clk_out) begin
        asel <= sel_use;
      end
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_clock_generator.sv
// Randomised bench for clock_generator: a period-level model predicts the clk
// edge index of every clk_out toggle; a monitor checks each observed toggle.
module tb_clock_generator;

  localparam logic [2:0] RSEL = 3'd0;
  localparam int HIST_N = 65536;

  logic       clk;
  logic       rst_n;
  logic [2:0] sel;
  logic       clk_out;

  clock_generator #(.RESET_SEL(RSEL)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sel     (sel),
    .clk_out (clk_out)
  );

  // ---------------- clock / reset / edge index ----------------
  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Number of clk rising edges seen since the last reset release.
  int edge_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  // Valid handshake: the monitor treats any clk_out change (with rst_n high)
  // as a presented output and pops one expected toggle edge per change.
  logic [2:0] sel_hist [0:HIST_N-1];
  int m_fall;

  function automatic logic [2:0] sel_seen(input int n);
`ifdef CLKGEN_SEL_SYNC_EN
    return (n >= 2) ? sel_hist[n-2] : 3'd0;
`else
    return sel_hist[n];
`endif
  endfunction

  // A new full output period begins at edge n: high for 2^a edges, low for 2^a.
  task automatic start_period(input int n, input int a);
    exp_q.push_back(32'(n + (1 << a)));
    m_fall = n + (2 << a);
    exp_q.push_back(32'(m_fall));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [2:0] v);
    int n;
    @(negedge clk);
    sel = v;
    n = edge_cnt + 1;
    if (n < HIST_N) begin
      sel_hist[n] = v;
      if (n == m_fall) start_period(n, int'(sel_seen(n)));
    end
  endtask

  task automatic hold(input logic [2:0] v, input int k);
    for (int i = 0; i < k; i++) step(v);
  endtask

  task automatic wait_high(input logic [2:0] v);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      step(v);
      if (clk_out) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_high: clk_out got 0 for 600 cycles, required a high phase");
    end
  endtask

  task automatic check_low(input string name);
    n_cmp++;
    if (clk_out !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: clk_out got %b, required 0", name, clk_out);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    sel_hist[0] = 3'd0;
    sel_hist[1] = sel;
    m_fall = 0;
    start_period(0, int'(RSEL));
  endtask

  // ---------------- monitor ----------------
  logic prev;
  initial begin
    prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev = 1'b0;
      end else if (clk_out !== prev) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL toggle_edge: got toggle at edge %0d, required none", edge_cnt);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (e != 32'(edge_cnt)) begin
            n_fail++;
            $display("FAIL toggle_edge: got toggle at edge %0d, required edge %0d", edge_cnt, e);
          end
        end
        prev = clk_out;
      end else if (exp_q.size() != 0 && 32'(edge_cnt) > exp_q[0]) begin
        n_cmp++;
        n_fail++;
        $display("FAIL missed_toggle: got no toggle by edge %0d, required edge %0d", edge_cnt, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    sel   = 3'd0;
    m_fall = -1;
    repeat (3) @(posedge clk);
    #10;
    check_low("reset_state");
    release_reset();

    // /2, then /4, then 1 -> 4 during a high phase, then /256.
    hold(3'd0, 20);
    hold(3'd1, 30);
    wait_high(3'd1);
    hold(3'd4, 80);
    hold(3'd7, 600);

    // 2 -> 5 -> 3 inside one period: only 3 may take effect.
    hold(3'd2, 30);
    wait_high(3'd2);
    step(3'd5);
    step(3'd3);
    hold(3'd3, 40);

    // Random codes with random hold times, including sub-period changes.
    for (int s = 0; s < 40; s++) begin
      logic [2:0] v;
      v = 3'($urandom_range(0, 7));
      hold(v, $urandom_range(1, 300));
    end

    // Reset while clk_out is high must drop it without a clock edge.
    wait_high(3'($urandom_range(1, 3)));
    #($urandom_range(5, 40));
    rst_n = 1'b0;
    #1;
    check_low("async_reset");
    exp_q.delete();
    m_fall = -1;
    repeat (3) @(posedge clk);
    #10;
    check_low("held_reset");
    release_reset();

    for (int s = 0; s < 15; s++) begin
      logic [2:0] v;
      v = 3'($urandom_range(0, 7));
      hold(v, $urandom_range(1, 300));
    end
    hold(3'd0, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
